// File: rtl/dmem_pkg.sv
// Shared types and constants for the variable data-memory arbiter.
// The window constants describe the default 128-word block at 0x800.
package dmem_pkg;

  typedef enum logic [0:0] {
    CPU_PRI = 1'b0,
    DBG_PRI = 1'b1
  } arb_state_e;

  localparam logic [31:0] VAR_BASE = 32'h0000_0800;
  localparam logic [31:0] VAR_LAST = 32'h0000_09FC;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: CPU data port, debug read port
// and the stall statistic. The arbiter uses the slave view, requesters the master view.
interface dmem_arbiter_if #(
  parameter int AW    = 7,
  parameter int CNT_W = 16
);
  logic             cpu_req;
  logic             cpu_we;
  logic [31:0]      cpu_addr;
  logic [31:0]      cpu_wdata;
  logic             cpu_stall;
  logic             cpu_rvalid;
  logic [31:0]      cpu_rdata;
  logic             cpu_err;
  logic             dbg_req;
  logic [AW-1:0]    dbg_addr;
  logic             dbg_rvalid;
  logic [31:0]      dbg_rdata;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_addr,
    output cpu_stall, cpu_rvalid, cpu_rdata, cpu_err, dbg_rvalid, dbg_rdata, stall_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_addr,
    input  cpu_stall, cpu_rvalid, cpu_rdata, cpu_err, dbg_rvalid, dbg_rdata, stall_cnt
  );
endinterface

// File: rtl/dmem_sp_ram.sv
// Single-port synchronous RAM, DEPTH x 32, with a registered read port.
// The array is deliberately not reset; a write and a read never share a cycle here.
module dmem_sp_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter for the variable data memory: CPU has fixed priority, but after MAX_WAIT
// consecutive lost conflicts the debug port wins once. Reads return one cycle later.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 128,
  parameter int          AW        = 7,
  parameter logic [31:0] BASE_ADDR = VAR_BASE,
  parameter int          MAX_WAIT  = 3,
  parameter int          CNT_W     = 16
) (
  input logic           CLK,
  input logic           RESET,
  dmem_arbiter_if.slave bus
);
  localparam int          WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * DEPTH) - 32'd4;

  arb_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  resp_t            cpu_resp_q, cpu_resp_d;
  logic             cpu_ram_q, cpu_ram_d;
  logic             dbg_ram_q, dbg_ram_d;
  logic [31:0]      dbg_hold_q, dbg_hold_d;

  logic             in_win, conflict, cpu_gnt, dbg_gnt, cpu_ram_gnt;
  logic [AW-1:0]    cpu_idx;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [31:0]      ram_rdata;
  logic [31:0]      cpu_rdata_now, dbg_rdata_now;

  dmem_sp_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk  (CLK),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(bus.cpu_wdata),
    .rdata(ram_rdata)
  );

  // Only an in-window CPU request competes for the RAM; out-of-window ones just error.
  always_comb begin
    in_win      = (bus.cpu_addr >= BASE_ADDR) && (bus.cpu_addr <= LAST_ADDR);
    cpu_idx     = bus.cpu_addr[AW+1:2];
    conflict    = bus.cpu_req && in_win && bus.dbg_req;
    cpu_gnt     = bus.cpu_req && !(conflict && (state_q == DBG_PRI));
    cpu_ram_gnt = cpu_gnt && in_win;
    dbg_gnt     = bus.dbg_req && !cpu_ram_gnt;
    ram_we      = cpu_ram_gnt && bus.cpu_we;
    if (cpu_ram_gnt) begin
      ram_addr = cpu_idx;
    end else begin
      ram_addr = bus.dbg_addr;
    end
  end

  // Starvation guard: count consecutive lost conflicts, anything else restarts it.
  always_comb begin
    state_d = CPU_PRI;
    wait_d  = '0;
    if (conflict) begin
      case (state_q)
        CPU_PRI: begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_d == WAIT_W'(MAX_WAIT)) begin
            state_d = DBG_PRI;
          end else begin
            state_d = CPU_PRI;
          end
        end
        DBG_PRI: begin
          state_d = CPU_PRI;
          wait_d  = '0;
        end
        default: begin
          state_d = CPU_PRI;
          wait_d  = '0;
        end
      endcase
    end else begin
      state_d = CPU_PRI;
      wait_d  = '0;
    end
  end

  // Read data comes from the RAM register while a read is returning, else the held value.
  always_comb begin
    if (cpu_ram_q) begin
      cpu_rdata_now = ram_rdata;
    end else begin
      cpu_rdata_now = cpu_resp_q.data;
    end
    if (dbg_ram_q) begin
      dbg_rdata_now = ram_rdata;
    end else begin
      dbg_rdata_now = dbg_hold_q;
    end
  end

  // Next response and statistic values.
  always_comb begin
    cpu_ram_d        = cpu_ram_gnt && !bus.cpu_we;
    cpu_resp_d.valid = cpu_gnt && !bus.cpu_we;
    cpu_resp_d.err   = cpu_gnt && !in_win;
    if (cpu_gnt && !in_win && !bus.cpu_we) begin
      cpu_resp_d.data = 32'h0000_0000;
    end else begin
      cpu_resp_d.data = cpu_rdata_now;
    end
    dbg_ram_d  = dbg_gnt;
    dbg_hold_d = dbg_rdata_now;
    if (bus.cpu_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // All arbiter state; reset discards any response in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= CPU_PRI;
      wait_q      <= '0;
      stall_cnt_q <= '0;
      cpu_resp_q  <= '0;
      cpu_ram_q   <= 1'b0;
      dbg_ram_q   <= 1'b0;
      dbg_hold_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      cpu_resp_q  <= cpu_resp_d;
      cpu_ram_q   <= cpu_ram_d;
      dbg_ram_q   <= dbg_ram_d;
      dbg_hold_q  <= dbg_hold_d;
    end
  end

  assign bus.cpu_stall  = bus.cpu_req && in_win && !cpu_gnt;
  assign bus.cpu_rvalid = cpu_resp_q.valid;
  assign bus.cpu_err    = cpu_resp_q.err;
  assign bus.cpu_rdata  = cpu_rdata_now;
  assign bus.dbg_rvalid = dbg_ram_q;
  assign bus.dbg_rdata  = dbg_rdata_now;
  assign bus.stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a table of per-cycle vectors plus hand sequences
// for reset during a read and stall-counter saturation (counter narrowed to 10 bits).
module tb_dmem_arbiter;
  localparam int TB_CNT_W = 10;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  dmem_arbiter_if #(.AW(7), .CNT_W(TB_CNT_W)) bus ();

  dmem_arbiter #(.CNT_W(TB_CNT_W)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Inputs applied in a cycle; expected outputs seen during that same cycle
  // (stall for this request, responses for the previous row's request).
  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        dreq;
    logic [6:0]  daddr;
    logic        stall;
    logic        crv;
    logic        cerr;
    logic [31:0] crd;
    logic        drv;
    logic [31:0] drd;
    int          scnt;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic req, input logic we, input logic [31:0] addr,
                   input logic [31:0] wdata, input logic dreq, input logic [6:0] daddr,
                   input logic stall, input logic crv, input logic cerr,
                   input logic [31:0] crd, input logic drv, input logic [31:0] drd,
                   input int scnt);
    vecs.push_back('{req, we, addr, wdata, dreq, daddr, stall, crv, cerr, crd, drv, drd, scnt});
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic dreq, input logic [6:0] daddr);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.dbg_req   = dreq;
    bus.dbg_addr  = daddr;
  endtask

  task automatic check_outputs(input string tag, input int idx, input logic stall,
                               input logic crv, input logic cerr, input logic [31:0] crd,
                               input logic drv, input logic [31:0] drd, input int scnt);
    check({tag, " cpu_stall"}, idx, {31'd0, bus.cpu_stall}, {31'd0, stall});
    check({tag, " cpu_rvalid"}, idx, {31'd0, bus.cpu_rvalid}, {31'd0, crv});
    check({tag, " cpu_err"}, idx, {31'd0, bus.cpu_err}, {31'd0, cerr});
    check({tag, " cpu_rdata"}, idx, bus.cpu_rdata, crd);
    check({tag, " dbg_rvalid"}, idx, {31'd0, bus.dbg_rvalid}, {31'd0, drv});
    check({tag, " dbg_rdata"}, idx, bus.dbg_rdata, drd);
    check({tag, " stall_cnt"}, idx, 32'(bus.stall_cnt), 32'(scnt));
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 7'd0);

    //  req  we    addr          wdata         dreq daddr  | stall crv  cerr crd           drv  drd           scnt
    v(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 0);
    v(1'b1, 1'b1, 32'h0000_0804, 32'h0000_000B, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 0);
    v(1'b1, 1'b0, 32'h0000_0804, 32'h0000_0000, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 0);
    v(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 7'd1,   1'b0, 1'b1, 1'b0, 32'h0000_000B, 1'b0, 32'h0000_0000, 0);
    v(1'b1, 1'b1, 32'h0000_0800, 32'h0000_0011, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 32'h0000_000B, 1'b1, 32'h0000_000B, 0);
    v(1'b1, 1'b0, 32'h0000_0204, 32'h0000_0000, 1'b1, 7'd0,   1'b0, 1'b0, 1'b0, 32'h0000_000B, 1'b0, 32'h0000_000B, 0);
    v(1'b1, 1'b1, 32'h0000_0A00, 32'h0000_DEAD, 1'b1, 7'd1,   1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0011, 0);
    v(1'b1, 1'b0, 32'h0000_0800, 32'h0000_0000, 1'b1, 7'd1,   1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_000B, 0);
    v(1'b1, 1'b0, 32'h0000_0800, 32'h0000_0000, 1'b1, 7'd1,   1'b0, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 32'h0000_000B, 0);
    v(1'b1, 1'b0, 32'h0000_0800, 32'h0000_0000, 1'b1, 7'd1,   1'b0, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 32'h0000_000B, 0);
    v(1'b1, 1'b0, 32'h0000_0800, 32'h0000_0000, 1'b1, 7'd1,   1'b1, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 32'h0000_000B, 0);
    v(1'b1, 1'b0, 32'h0000_0800, 32'h0000_0000, 1'b1, 7'd1,   1'b0, 1'b0, 1'b0, 32'h0000_0011, 1'b1, 32'h0000_000B, 1);
    v(1'b1, 1'b0, 32'h0000_0800, 32'h0000_0000, 1'b1, 7'd1,   1'b0, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 32'h0000_000B, 1);
    v(1'b1, 1'b0, 32'h0000_0800, 32'h0000_0000, 1'b1, 7'd1,   1'b0, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 32'h0000_000B, 1);
    v(1'b1, 1'b0, 32'h0000_0800, 32'h0000_0000, 1'b1, 7'd1,   1'b1, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 32'h0000_000B, 1);
    v(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 32'h0000_0011, 1'b1, 32'h0000_000B, 2);
    v(1'b1, 1'b1, 32'h0000_09FC, 32'h0000_007F, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 32'h0000_0011, 1'b0, 32'h0000_000B, 2);
    v(1'b1, 1'b0, 32'h0000_09FC, 32'h0000_0000, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 32'h0000_0011, 1'b0, 32'h0000_000B, 2);
    v(1'b1, 1'b0, 32'h0000_07FC, 32'h0000_0000, 1'b1, 7'd127, 1'b0, 1'b1, 1'b0, 32'h0000_007F, 1'b0, 32'h0000_000B, 2);
    v(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 7'd0,   1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_007F, 2);
    v(1'b1, 1'b0, 32'h0000_0800, 32'h0000_0000, 1'b1, 7'd1,   1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_007F, 2);
    v(1'b1, 1'b0, 32'h0000_0800, 32'h0000_0000, 1'b1, 7'd1,   1'b0, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 32'h0000_007F, 2);
    v(1'b1, 1'b0, 32'h0000_0800, 32'h0000_0000, 1'b0, 7'd0,   1'b0, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 32'h0000_007F, 2);
    v(1'b1, 1'b0, 32'h0000_0800, 32'h0000_0000, 1'b1, 7'd1,   1'b0, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 32'h0000_007F, 2);
    v(1'b1, 1'b0, 32'h0000_0800, 32'h0000_0000, 1'b1, 7'd1,   1'b0, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 32'h0000_007F, 2);
    v(1'b1, 1'b0, 32'h0000_0800, 32'h0000_0000, 1'b1, 7'd1,   1'b0, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 32'h0000_007F, 2);
    v(1'b1, 1'b0, 32'h0000_0800, 32'h0000_0000, 1'b1, 7'd1,   1'b1, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 32'h0000_007F, 2);
    v(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 32'h0000_0011, 1'b1, 32'h0000_000B, 3);

    repeat (3) @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      drive(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].dreq, vecs[i].daddr);
      #1;
      check_outputs("row", i, vecs[i].stall, vecs[i].crv, vecs[i].cerr, vecs[i].crd,
                    vecs[i].drv, vecs[i].drd, vecs[i].scnt);
    end

    // Reset arriving while a read response is being presented wipes every output.
    @(negedge CLK);
    drive(1'b1, 1'b0, 32'h0000_0804, 32'h0, 1'b0, 7'd0);
    @(posedge CLK);
    #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 7'd0);
    check("pre-reset cpu_rvalid", 0, {31'd0, bus.cpu_rvalid}, 32'd1);
    check("pre-reset cpu_rdata", 0, bus.cpu_rdata, 32'h0000_000B);
    #1;
    RESET = 1'b1;
    #1;
    check_outputs("in-reset", 0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 0);
    @(negedge CLK);
    RESET = 1'b0;
    drive(1'b1, 1'b0, 32'h0000_0804, 32'h0, 1'b0, 7'd0);
    @(negedge CLK);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 7'd0);
    #1;
    check_outputs("post-reset read", 0, 1'b0, 1'b1, 1'b0, 32'h0000_000B, 1'b0, 32'h0, 0);

    // Continuous conflict: one stall per four cycles until the counter pins at all-ones.
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    drive(1'b1, 1'b0, 32'h0000_0800, 32'h0, 1'b1, 7'd1);
    repeat (4000) @(posedge CLK);
    #1;
    check("stall_cnt after 1000 stalls", 0, 32'(bus.stall_cnt), 32'd1000);
    repeat (400) @(posedge CLK);
    #1;
    check("stall_cnt saturated", 0, 32'(bus.stall_cnt), 32'h0000_03FF);
    @(negedge CLK);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 7'd0);
    @(negedge CLK);
    check("stall_cnt held when idle", 0, 32'(bus.stall_cnt), 32'h0000_03FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
